imem_boot_loader: RTL

//  Parametrised instruction-memory boot loader for the single-cycle CPU. Replaces the ad-hoc

---
 rtl/cpu_pkg.sv | 17 +
 rtl/imem_array.sv | 26 ++
 rtl/imem_boot_loader.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle CPU and its instruction-memory boot loader.
package cpu_pkg;

  localparam logic [31:0] NOP_WORD   = 32'h0;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic LOAD_MODE_EXPLICIT = 1'b0;
  localparam logic LOAD_MODE_AUTO     = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StLoad,
    StDone
  } loader_state_e;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
module imem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Callers guarantee raddr < DEPTH whenever the result is used.
  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: clears the instruction array, streams a program in, then releases the CPU
// and serves combinational fetch.
module imem_boot_loader
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 32,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_mode,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_done,
  output logic              load_err,
  output logic [CNT_W-1:0]  load_count,
  output logic              cpu_rst,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  loader_state_e    state_q, state_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  logic [ADDR_W-1:0] exp_word, fetch_word;
  logic              exp_ok, auto_ok, beat_ok;
  logic [IDX_W-1:0]  beat_idx;

  assign exp_word   = load_addr >> 2;
  assign fetch_word = fetch_addr >> 2;
  assign exp_ok     = (load_addr[1:0] == 2'b00) && (exp_word < ADDR_W'(DEPTH));
  assign auto_ok    = wr_ptr_q < CNT_W'(DEPTH);
  assign beat_ok    = (mode_q == LOAD_MODE_AUTO) ? auto_ok : exp_ok;
  assign beat_idx   = (mode_q == LOAD_MODE_AUTO) ? wr_ptr_q[IDX_W-1:0] : exp_word[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mode_q    <= LOAD_MODE_EXPLICIT;
      err_q     <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      err_q     <= err_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    err_d      = err_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    clr_ptr_d  = clr_ptr_q;
    wr_en      = 1'b0;
    wr_idx     = '0;
    wr_data    = DATA_W'(NOP_WORD);
    load_ready = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (load_start) begin
          state_d   = StClear;
          mode_d    = load_mode;
          err_d     = 1'b0;
          count_d   = '0;
          wr_ptr_d  = '0;
          clr_ptr_d = '0;
        end
      end
      StClear: begin
        wr_en  = 1'b1;
        wr_idx = clr_ptr_q;
        if (clr_ptr_q == IDX_W'(DEPTH - 1)) begin
          state_d = StLoad;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      StLoad: begin
        load_ready = 1'b1;
        if (load_valid) begin
          if (beat_ok) begin
            wr_en   = 1'b1;
            wr_idx  = beat_idx;
            wr_data = load_data;
            if (count_q != '1) begin
              count_d = count_q + 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
          // Saturate at DEPTH so later beats keep being recognised as overflow.
          if (mode_q == LOAD_MODE_AUTO && auto_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
          if (load_last) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Gate with rst_n so a reset cycle mid-stream never commits a write.
  imem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (wr_en & rst_n),
    .waddr(wr_idx),
    .wdata(wr_data),
    .raddr(fetch_word[IDX_W-1:0]),
    .rdata(rd_data)
  );

  assign load_done  = (state_q == StDone);
  assign cpu_rst    = ~load_done;
  assign load_err   = err_q;
  assign load_count = count_q;
  assign fetch_data = (load_done && fetch_word < ADDR_W'(DEPTH)) ? rd_data : DATA_W'(NOP_WORD);

endmodule
